// File: rtl/mem_access_stage_pkg.sv
// Purpose: shared types and constants for the MEM pipeline stage.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
// Contents: FSM state encoding, register/data widths, word-alignment helper.
package mem_access_stage_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_t;

  // True when the byte offset inside a word is non-zero.
  function automatic logic is_misaligned(input logic [1:0] lsb);
    return (lsb & WORD_ALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/mem_wb_register.sv
// Purpose: MEM/WB pipeline flop bank with bubble and fault insertion.
// Latency: one clock edge from stage inputs to WB outputs.
// Backpressure: none; a bubble clears reg_write/fault and holds the data fields.
// Ports: clk, reset (async active-low); bubble, fault, rdata_load controls;
//        pass-through fields in; registered *_wb fields out.
module mem_wb_register
  import mem_access_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  bubble,
  input  logic                  fault,
  input  logic                  reg_write,
  input  logic                  mem_to_reg,
  input  logic [DATA_W-1:0]     alu_result,
  input  logic [REG_ADDR_W-1:0] write_reg_addr,
  input  logic                  rdata_load,
  input  logic [DATA_W-1:0]     rdata,
  output logic                  reg_write_wb,
  output logic                  mem_to_reg_wb,
  output logic [DATA_W-1:0]     read_data_wb,
  output logic [DATA_W-1:0]     alu_result_wb,
  output logic [REG_ADDR_W-1:0] write_reg_addr_wb,
  output logic                  mem_fault_wb
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reg_write_wb      <= 1'b0;
      mem_to_reg_wb     <= 1'b0;
      read_data_wb      <= '0;
      alu_result_wb     <= '0;
      write_reg_addr_wb <= '0;
      mem_fault_wb      <= 1'b0;
    end else begin
      // The fault flag is a single-cycle pulse unless re-asserted below.
      mem_fault_wb <= 1'b0;
      if (bubble) begin
        reg_write_wb <= 1'b0;
      end else begin
        // A faulting instruction still reaches WB so it can be identified,
        // but it must never write the register file.
        reg_write_wb      <= reg_write & ~fault;
        mem_fault_wb      <= fault;
        mem_to_reg_wb     <= mem_to_reg;
        alu_result_wb     <= alu_result;
        write_reg_addr_wb <= write_reg_addr;
      end
      if (rdata_load) begin
        read_data_wb <= rdata;
      end
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// Purpose: MEM pipeline stage; data-memory access over a req/ready bus into MEM/WB.
// Latency: WB outputs valid one edge after the completing cycle (zero-wait = 1 cycle).
// Backpressure: mem_stall freezes upstream while an access waits; aborts after TIMEOUT_CYCLES.
// Ports: EX/MEM controls and data in; dmem_* bus; mem_stall; registered *_wb outputs.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic                  reg_write,
  input  logic                  mem_to_reg,
  input  logic [DATA_W-1:0]     alu_result,
  input  logic [DATA_W-1:0]     write_data,
  input  logic [REG_ADDR_W-1:0] write_reg_addr,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_W-1:0]     dmem_addr,
  output logic [DATA_W-1:0]     dmem_wdata,
  input  logic [DATA_W-1:0]     dmem_rdata,
  input  logic                  dmem_ready,
  output logic                  mem_stall,
  output logic                  reg_write_wb,
  output logic                  mem_to_reg_wb,
  output logic [DATA_W-1:0]     read_data_wb,
  output logic [DATA_W-1:0]     alu_result_wb,
  output logic [REG_ADDR_W-1:0] write_reg_addr_wb,
  output logic                  mem_fault_wb
);

  mem_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             access, misaligned;
  logic             req, stall, timeout_abort;
  logic             complete, fault, rdata_load;

  assign access     = mem_read | mem_write;
  assign misaligned = access & is_misaligned(alu_result[1:0]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= MEM_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    req           = 1'b0;
    stall         = 1'b0;
    timeout_abort = 1'b0;
    case (state_q)
      MEM_IDLE: begin
        if (access && !misaligned) begin
          req = 1'b1;
          if (!dmem_ready) begin
            stall   = 1'b1;
            state_d = MEM_WAIT;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      MEM_WAIT: begin
        // Upstream is frozen, so the inputs still describe the same access.
        req = 1'b1;
        if (dmem_ready) begin
          state_d = MEM_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
          // Request stays up in the abort cycle; the instruction leaves as a fault.
          timeout_abort = 1'b1;
          state_d       = MEM_IDLE;
          cnt_d         = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          stall = 1'b1;
        end
      end
      default: begin
        state_d = MEM_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Reset must drop the request immediately, even mid-WAIT with live inputs.
  assign dmem_req   = req & reset;
  assign mem_stall  = stall & reset;
  assign dmem_we    = mem_write;
  assign dmem_addr  = alu_result[ADDR_W-1:0] & ~ADDR_W'(WORD_ALIGN_MASK);
  assign dmem_wdata = write_data;

  assign complete   = req & dmem_ready;
  assign fault      = misaligned | timeout_abort;
  // Write wins over read, so a combined request never loads read data.
  assign rdata_load = complete & ~mem_write;

  mem_wb_register u_mem_wb (
    .clk               (clk),
    .reset             (reset),
    .bubble            (stall),
    .fault             (fault),
    .reg_write         (reg_write),
    .mem_to_reg        (mem_to_reg),
    .alu_result        (alu_result),
    .write_reg_addr    (write_reg_addr),
    .rdata_load        (rdata_load),
    .rdata             (dmem_rdata),
    .reg_write_wb      (reg_write_wb),
    .mem_to_reg_wb     (mem_to_reg_wb),
    .read_data_wb      (read_data_wb),
    .alu_result_wb     (alu_result_wb),
    .write_reg_addr_wb (write_reg_addr_wb),
    .mem_fault_wb      (mem_fault_wb)
  );

endmodule

// File: tb/tb_mem_access_stage.sv
// Purpose: self-checking bench for mem_access_stage (vector table + corner sequences).
// Latency: expects WB results one edge after each non-stalled cycle.
// Backpressure: stalled cycles must produce WB bubbles.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read, mem_write, reg_write, mem_to_reg;
  logic [31:0] alu_result, write_data;
  logic [4:0]  write_reg_addr;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ready, mem_stall;
  logic        reg_write_wb, mem_to_reg_wb, mem_fault_wb;
  logic [31:0] read_data_wb, alu_result_wb;
  logic [4:0]  write_reg_addr_wb;

  always #5 clk = ~clk;

  mem_access_stage #(.ADDR_W(32), .TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
    .clk               (clk),
    .reset             (reset),
    .mem_read          (mem_read),
    .mem_write         (mem_write),
    .reg_write         (reg_write),
    .mem_to_reg        (mem_to_reg),
    .alu_result        (alu_result),
    .write_data        (write_data),
    .write_reg_addr    (write_reg_addr),
    .dmem_req          (dmem_req),
    .dmem_we           (dmem_we),
    .dmem_addr         (dmem_addr),
    .dmem_wdata        (dmem_wdata),
    .dmem_rdata        (dmem_rdata),
    .dmem_ready        (dmem_ready),
    .mem_stall         (mem_stall),
    .reg_write_wb      (reg_write_wb),
    .mem_to_reg_wb     (mem_to_reg_wb),
    .read_data_wb      (read_data_wb),
    .alu_result_wb     (alu_result_wb),
    .write_reg_addr_wb (write_reg_addr_wb),
    .mem_fault_wb      (mem_fault_wb)
  );

  typedef struct {
    logic        rd, wr, rw, m2r;
    logic [31:0] alu, wdata, rdata;
    logic [4:0]  wreg;
    logic        ready;
    logic        exp_req, exp_stall, exp_fault;
  } vec_t;

  typedef struct {
    logic        rw, m2r, fault;
    logic [31:0] alu, rdata;
    logic [4:0]  wreg;
  } wb_exp_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  wb_exp_t     sb[$];
  logic [31:0] shadow_rdata = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_wb_zero(input string tag);
    check({tag, ".dmem_req"}, {31'b0, dmem_req}, 32'h0);
    check({tag, ".reg_write_wb"}, {31'b0, reg_write_wb}, 32'h0);
    check({tag, ".mem_to_reg_wb"}, {31'b0, mem_to_reg_wb}, 32'h0);
    check({tag, ".read_data_wb"}, read_data_wb, 32'h0);
    check({tag, ".alu_result_wb"}, alu_result_wb, 32'h0);
    check({tag, ".write_reg_addr_wb"}, {27'b0, write_reg_addr_wb}, 32'h0);
    check({tag, ".mem_fault_wb"}, {31'b0, mem_fault_wb}, 32'h0);
  endtask

  function automatic vec_t mk(input logic rd, wr, rw, m2r, input logic [31:0] alu, wdata,
                              input logic [4:0] wreg, input logic ready, input logic [31:0] rdata,
                              input logic exp_req, exp_stall, exp_fault);
    vec_t v;
    v.rd = rd; v.wr = wr; v.rw = rw; v.m2r = m2r; v.alu = alu; v.wdata = wdata;
    v.wreg = wreg; v.ready = ready; v.rdata = rdata;
    v.exp_req = exp_req; v.exp_stall = exp_stall; v.exp_fault = exp_fault;
    return v;
  endfunction

  // Called at posedge+1: drive, check combinational bus outputs just before
  // the next edge, then compare the WB register after that edge.
  task automatic run_cycle(input vec_t v, input string tag);
    wb_exp_t e;
    mem_read = v.rd; mem_write = v.wr; reg_write = v.rw; mem_to_reg = v.m2r;
    alu_result = v.alu; write_data = v.wdata; write_reg_addr = v.wreg;
    dmem_ready = v.ready; dmem_rdata = v.rdata;
    @(negedge clk); #4;
    check({tag, ".dmem_req"}, {31'b0, dmem_req}, {31'b0, v.exp_req});
    check({tag, ".mem_stall"}, {31'b0, mem_stall}, {31'b0, v.exp_stall});
    if (v.exp_req) begin
      check({tag, ".dmem_we"}, {31'b0, dmem_we}, {31'b0, v.wr});
      check({tag, ".dmem_addr"}, dmem_addr, v.alu & ~32'h3);
      check({tag, ".dmem_wdata"}, dmem_wdata, v.wdata);
    end
    if (!v.exp_stall) begin
      e.rw = v.rw & ~v.exp_fault;
      e.m2r = v.m2r;
      e.fault = v.exp_fault;
      e.alu = v.alu;
      e.wreg = v.wreg;
      if (v.exp_req && v.ready && !v.wr) shadow_rdata = v.rdata;
      e.rdata = shadow_rdata;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, ".reg_write_wb"}, {31'b0, reg_write_wb}, {31'b0, e.rw});
      check({tag, ".mem_fault_wb"}, {31'b0, mem_fault_wb}, {31'b0, e.fault});
      check({tag, ".alu_result_wb"}, alu_result_wb, e.alu);
      check({tag, ".write_reg_addr_wb"}, {27'b0, write_reg_addr_wb}, {27'b0, e.wreg});
      check({tag, ".read_data_wb"}, read_data_wb, e.rdata);
      if (!e.fault) check({tag, ".mem_to_reg_wb"}, {31'b0, mem_to_reg_wb}, {31'b0, e.m2r});
    end else begin
      check({tag, ".bubble_reg_write_wb"}, {31'b0, reg_write_wb}, 32'h0);
      check({tag, ".bubble_mem_fault_wb"}, {31'b0, mem_fault_wb}, 32'h0);
    end
  endtask

  vec_t vecs[8];
  vec_t v;

  initial begin
    reset = 1'b0;
    mem_read = 0; mem_write = 0; reg_write = 0; mem_to_reg = 0;
    alu_result = 0; write_data = 0; write_reg_addr = 0;
    dmem_ready = 0; dmem_rdata = 0;

    //              rd wr rw m2r alu           wdata         wreg ready rdata         req stall fault
    vecs[0] = mk(1, 0, 1, 1, 32'h0000_0100, 32'h0,        5'd5,  1, 32'hDEADBEEF, 1, 0, 0);
    vecs[1] = mk(0, 0, 1, 0, 32'h0000_0055, 32'h0,        5'd9,  0, 32'h0,        0, 0, 0);
    vecs[2] = mk(1, 0, 1, 1, 32'h0000_0102, 32'h0,        5'd3,  0, 32'h0,        0, 0, 1);
    vecs[3] = mk(0, 1, 0, 0, 32'h0000_0201, 32'h77,       5'd0,  1, 32'h0,        0, 0, 1);
    vecs[4] = mk(0, 1, 0, 0, 32'h0000_0044, 32'hCAFEF00D, 5'd0,  1, 32'h11111111, 1, 0, 0);
    vecs[5] = mk(1, 1, 0, 0, 32'h0000_0048, 32'hA5A5A5A5, 5'd2,  1, 32'h22222222, 1, 0, 0);
    vecs[6] = mk(0, 0, 1, 0, 32'h0000_0077, 32'h0,        5'd7,  1, 32'h33333333, 0, 0, 0);
    vecs[7] = mk(1, 0, 1, 1, 32'h0000_FFFC, 32'h0,        5'd31, 1, 32'h0BADF00D, 1, 0, 0);

    #2;
    check_wb_zero("reset_state");
    #10 reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) run_cycle(vecs[i], $sformatf("vec%0d", i));

    // Store with three wait cycles, completing on the fourth.
    v = mk(0, 1, 0, 0, 32'h20, 32'h1234, 5'd0, 0, 32'h0, 1, 1, 0);
    for (int i = 0; i < 3; i++) run_cycle(v, $sformatf("st3w_wait%0d", i));
    v.ready = 1'b1; v.exp_stall = 1'b0;
    run_cycle(v, "st3w_done");

    // Timeout: 16 stalled cycles, then an abort cycle with request still up.
    v = mk(1, 0, 1, 1, 32'h40, 32'h0, 5'd12, 0, 32'h0, 1, 1, 0);
    for (int i = 0; i < 16; i++) run_cycle(v, $sformatf("tmo_wait%0d", i));
    v.exp_stall = 1'b0; v.exp_fault = 1'b1;
    run_cycle(v, "tmo_abort");
    run_cycle(mk(1, 0, 1, 1, 32'h60, 32'h0, 5'd13, 1, 32'h600DCAFE, 1, 0, 0), "after_tmo");

    // Reset asserted in the second wait cycle, checked without a clock edge.
    v = mk(1, 0, 1, 1, 32'h80, 32'h0, 5'd4, 0, 32'h0, 1, 1, 0);
    run_cycle(v, "rst_wait0");
    run_cycle(v, "rst_wait1");
    reset = 1'b0;
    #1;
    check_wb_zero("rst_mid_wait");
    shadow_rdata = 32'h0;
    mem_read = 0; mem_write = 0; reg_write = 0; mem_to_reg = 0;
    alu_result = 0; write_reg_addr = 0; dmem_ready = 0;
    #2 reset = 1'b1;
    @(posedge clk); #1;
    run_cycle(mk(1, 0, 1, 1, 32'h84, 32'h0, 5'd6, 1, 32'h5A5A5A5A, 1, 0, 0), "after_rst");

    check("scoreboard_drained", sb.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
